// File: rtl/mod_addsub_pipe_if.sv
// Valid/ready bundle for the multi-lane modular add/sub pipeline.
// Lane i of each vector sits at bits [i*W +: W].
interface mod_addsub_pipe_if #(
  parameter int unsigned W     = 12,
  parameter int unsigned LANES = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_op;
  logic [LANES*W-1:0]   in_a;
  logic [LANES*W-1:0]   in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*W-1:0]   out_result;
  logic [LANES-1:0]     out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_err
  );
endinterface

// File: rtl/mod_addsub_pipe.sv
// Two-stage, multi-lane modular add/subtract over Z_q.
// S1 holds the raw W+1 bit sum/difference, S2 the corrected result.
module mod_addsub_pipe #(
  parameter int unsigned Q     = 3329,
  parameter int unsigned W     = 12,
  parameter int unsigned LANES = 4
) (
  input  logic              clk,
  input  logic              rst,
  mod_addsub_pipe_if.slave  bus
);

  typedef logic [W-1:0] coef_t;
  typedef logic [W:0]   raw_t;

  localparam coef_t QC = coef_t'(Q);
  localparam raw_t  QR = raw_t'(Q);

  typedef struct packed {
    logic                  op;
    logic [LANES-1:0]      err;
    logic [LANES-1:0][W:0] raw;
  } s1_t;

  typedef struct packed {
    logic [LANES*W-1:0] res;
    logic [LANES-1:0]   err;
  } s2_t;

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;

  logic s1_adv, s2_adv;

  assign s2_adv = !s2_valid_q || bus.out_ready;
  assign s1_adv = !s1_valid_q || s2_adv;

  assign bus.in_ready   = s1_adv;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_result = s2_q.res;
  assign bus.out_err    = s2_q.err;

  always_comb begin
    coef_t a, b;
    a          = '0;
    b          = '0;
    s1_d       = s1_q;
    s1_valid_d = s1_adv ? bus.in_valid : s1_valid_q;
    if (s1_adv && bus.in_valid) begin
      s1_d.op = bus.in_op;
      for (int i = 0; i < LANES; i++) begin
        a = bus.in_a[i*W +: W];
        b = bus.in_b[i*W +: W];
        s1_d.raw[i] = bus.in_op ? ({1'b0, a} - {1'b0, b})
                                : ({1'b0, a} + {1'b0, b});
        s1_d.err[i] = (a >= QC) || (b >= QC);
      end
    end
  end

  // One conditional correction per lane; bubbles leave S2 data untouched.
  always_comb begin
    raw_t  r;
    coef_t fix;
    r          = '0;
    fix        = '0;
    s2_d       = s2_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    if (s2_adv && s1_valid_q) begin
      s2_d.err = s1_q.err;
      for (int i = 0; i < LANES; i++) begin
        r = s1_q.raw[i];
        if (s1_q.op)
          fix = coef_t'(r[W] ? r + QR : r);
        else
          fix = coef_t'((r >= QR) ? r - QR : r);
        s2_d.res[i*W +: W] = fix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed bench for mod_addsub_pipe: reset, add/sub corners,
// streaming, backpressure, range flags and reset during stall.
module tb_mod_addsub_pipe;

  localparam int unsigned Q  = 3329;
  localparam int unsigned W  = 12;
  localparam int unsigned L  = 4;
  localparam int unsigned DW = L * W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mod_addsub_pipe_if #(.W(W), .LANES(L)) bus ();

  mod_addsub_pipe #(.Q(Q), .W(W), .LANES(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pk(input int l0, input int l1,
                                       input int l2, input int l3);
    return {l3[W-1:0], l2[W-1:0], l1[W-1:0], l0[W-1:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  logic [DW-1:0] ta [8];
  logic [DW-1:0] tb [8];
  logic [DW-1:0] te [8];
  logic          top[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int idx;
    logic acc;

    top[0] = 0; ta[0] = pk(100, 200, 3000, 3328);
    tb[0] = pk(50, 3200, 400, 2);        te[0] = pk(150, 71, 71, 1);
    top[1] = 1; ta[1] = pk(100, 200, 3000, 0);
    tb[1] = pk(50, 3200, 400, 3328);     te[1] = pk(50, 329, 2600, 1);
    top[2] = 0; ta[2] = pk(1, 2, 3, 4);
    tb[2] = pk(5, 6, 7, 8);              te[2] = pk(6, 8, 10, 12);
    top[3] = 1; ta[3] = pk(1, 2, 3, 4);
    tb[3] = pk(5, 6, 7, 8);              te[3] = pk(3325, 3325, 3325, 3325);
    top[4] = 0; ta[4] = pk(1664, 1665, 3328, 0);
    tb[4] = pk(1664, 1664, 0, 3328);     te[4] = pk(3328, 0, 3328, 3328);
    top[5] = 1; ta[5] = pk(1664, 1665, 3328, 0);
    tb[5] = pk(1664, 1664, 0, 3328);     te[5] = pk(0, 1, 3328, 1);
    top[6] = 0; ta[6] = pk(2000, 2500, 1234, 777);
    tb[6] = pk(1329, 829, 2095, 2552);   te[6] = pk(0, 0, 0, 0);
    top[7] = 1; ta[7] = pk(2000, 2500, 1234, 777);
    tb[7] = pk(1329, 829, 2095, 2552);   te[7] = pk(671, 1671, 2468, 1554);

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    step();
    drive(1'b0, pk(3328, 3328, 0, 1664), pk(3328, 1, 0, 1665));
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("add_lat1_valid", bus.out_valid, 0);
    step();
    @(negedge clk);
    chk("add_valid", bus.out_valid, 1);
    chk("add_result", bus.out_result, pk(3327, 0, 0, 0));
    chk("add_err", bus.out_err, 0);

    step();
    drive(1'b1, pk(0, 0, 3328, 5), pk(1, 3328, 0, 5));
    step();
    bus.in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("sub_valid", bus.out_valid, 1);
    chk("sub_result", bus.out_result, pk(3328, 1, 3328, 0));
    chk("sub_err", bus.out_err, 0);

    // Full-rate stream: results appear in cycles 2..9
    step();
    k = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive(top[c], ta[c], tb[c]);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (c < 8) chk("stream_in_ready", bus.in_ready, 1);
      chk("stream_valid", bus.out_valid, (c >= 2 && c <= 9));
      if (bus.out_valid && k < 8) begin
        chk("stream_result", bus.out_result, te[k]);
        chk("stream_err", bus.out_err, 0);
        k++;
      end
      step();
    end
    chk("stream_count", k, 8);

    k   = 0;
    idx = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      bus.out_ready = !(c >= 2 && c <= 6);
      if (idx < 8) drive(top[idx], ta[idx], tb[idx]);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (c >= 2 && c <= 6) begin
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_valid", bus.out_valid, 1);
      end
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        chk("stall_result", bus.out_result, te[k]);
        if (bus.out_ready) k++;
      end
      step();
      if (acc) idx++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stall_count", k, 8);
    chk("stall_accepts", idx, 8);
    @(negedge clk);
    chk("stall_drained", bus.out_valid, 0);

    step();
    drive(1'b0, pk(10, 20, 3329, 40), pk(1, 2, 3, 4));
    step();
    drive(1'b1, pk(4095, 7, 8, 9), pk(0, 7, 3328, 4000));
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("range_add_err", bus.out_err, 4'b0100);
    chk("range_add_res",
        bus.out_result & pk(4095, 4095, 0, 4095), pk(11, 22, 0, 44));
    step();
    @(negedge clk);
    chk("range_sub_err", bus.out_err, 4'b1001);
    chk("range_sub_res",
        bus.out_result & pk(0, 4095, 4095, 0), pk(0, 0, 9, 0));

    step();
    bus.out_ready = 1'b0;
    drive(top[2], ta[2], tb[2]);
    step();
    drive(top[3], ta[3], tb[3]);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rststall_valid", bus.out_valid, 1);
    chk("rststall_in_ready", bus.in_ready, 0);
    step();
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rststall_out_valid", bus.out_valid, 0);
    chk("rststall_out_result", bus.out_result, 0);
    chk("rststall_out_err", bus.out_err, 0);
    chk("rststall_ready", bus.in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      step();
      @(negedge clk);
      chk("rststall_no_data", bus.out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
